// File: rtl/spi_slave_transmitter_if.sv
// Bus bundle between an SD-style SPI command core and its MISO transmitter.
// The slave modport is the transmitter side; the master modport drives requests and SCK/CS.
interface spi_slave_transmitter_if #(
    parameter int SIZE_W = 12
);
    logic              io_SpiClk;
    logic              io_CS;
    logic              io_DO;
    logic              io_RespValid;
    logic [39:0]       io_RespData;
    logic              io_RespLong;
    logic              io_DataStart;
    logic [SIZE_W-1:0] io_DataBlockSize;
    logic              io_DataReq;
    logic [7:0]        io_DataByte;
    logic              io_Busy;
    logic              io_Done;

    modport slave (
        input  io_SpiClk,
        input  io_CS,
        input  io_RespValid,
        input  io_RespData,
        input  io_RespLong,
        input  io_DataStart,
        input  io_DataBlockSize,
        input  io_DataByte,
        output io_DO,
        output io_DataReq,
        output io_Busy,
        output io_Done
    );

    modport master (
        output io_SpiClk,
        output io_CS,
        output io_RespValid,
        output io_RespData,
        output io_RespLong,
        output io_DataStart,
        output io_DataBlockSize,
        output io_DataByte,
        input  io_DO,
        input  io_DataReq,
        input  io_Busy,
        input  io_Done
    );
endinterface

// File: rtl/spi_slave_transmitter.sv
// SPI MISO transmitter: R1/R3/R7 responses, then an optional data block framed by a 0xFE token
// and a CRC-CCITT trailer. SCK is oversampled; each detected falling edge advances one bit.
module spi_slave_transmitter #(
    parameter int SIZE_W = 12
) (
    input logic                    clock,
    input logic                    reset,
    spi_slave_transmitter_if.slave io
);

    typedef enum logic [2:0] {
        IDLE,
        RESP,
        TOKEN,
        DATA,
        CRC
    } state_t;

    state_t            state, state_n;
    logic              sck_prev;
    logic              sck_fall;
    logic [7:0]        shift, shift_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [2:0]        byte_idx, byte_idx_n;
    logic [SIZE_W-1:0] byte_cnt, byte_cnt_n;
    logic [SIZE_W-1:0] last_idx, last_idx_n;
    logic [39:0]       resp_data, resp_data_n;
    logic              resp_long, resp_long_n;
    logic              pending, pending_n;
    logic [15:0]       crc, crc_n, crc_step;
    logic [7:0]        next_byte, next_byte_n;
    logic              req, req_n, req_d;
    logic              done, done_n;

    function automatic logic [7:0] resp_byte(input logic [39:0] d, input logic [2:0] i);
        case (i)
            3'd0:    return d[39:32];
            3'd1:    return d[31:24];
            3'd2:    return d[23:16];
            3'd3:    return d[15:8];
            default: return d[7:0];
        endcase
    endfunction

    assign sck_fall = sck_prev & ~io.io_SpiClk;

    // CRC advances with the payload bit that the current falling edge retires.
    always_comb begin
        crc_step = {crc[14:0], 1'b0};
        if (crc[15] ^ shift[7]) crc_step = crc_step ^ 16'h1021;
    end

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        bit_cnt_n   = bit_cnt;
        byte_idx_n  = byte_idx;
        byte_cnt_n  = byte_cnt;
        last_idx_n  = last_idx;
        resp_data_n = resp_data;
        resp_long_n = resp_long;
        pending_n   = pending;
        crc_n       = crc;
        next_byte_n = req_d ? io.io_DataByte : next_byte;
        req_n       = 1'b0;
        done_n      = 1'b0;

        if (state == IDLE) begin
            if (!io.io_CS && (io.io_RespValid || io.io_DataStart)) begin
                resp_data_n = io.io_RespData;
                resp_long_n = io.io_RespLong;
                last_idx_n  = (io.io_DataBlockSize == '0) ? '0 : io.io_DataBlockSize - 1'b1;
                bit_cnt_n   = '0;
                byte_idx_n  = '0;
                byte_cnt_n  = '0;
                if (io.io_RespValid) begin
                    state_n   = RESP;
                    shift_n   = io.io_RespData[39:32];
                    pending_n = io.io_DataStart;
                end else begin
                    state_n   = TOKEN;
                    shift_n   = 8'hFE;
                    crc_n     = '0;
                    pending_n = 1'b0;
                end
            end
        end else if (io.io_CS) begin
            state_n    = IDLE;
            pending_n  = 1'b0;
            bit_cnt_n  = '0;
            byte_idx_n = '0;
            byte_cnt_n = '0;
        end else if (sck_fall) begin
            if (state == DATA) crc_n = crc_step;

            if (bit_cnt != 3'd7) begin
                shift_n   = {shift[6:0], 1'b1};
                bit_cnt_n = bit_cnt + 3'd1;
                // Fetch the following payload byte a full byte-time ahead of its use.
                if (bit_cnt == 3'd0 &&
                    (state == TOKEN || (state == DATA && byte_cnt != last_idx)))
                    req_n = 1'b1;
            end else begin
                bit_cnt_n = '0;
                case (state)
                    RESP: begin
                        if (resp_long && byte_idx != 3'd4) begin
                            byte_idx_n = byte_idx + 3'd1;
                            shift_n    = resp_byte(resp_data, byte_idx + 3'd1);
                        end else if (pending) begin
                            state_n    = TOKEN;
                            shift_n    = 8'hFE;
                            crc_n      = '0;
                            pending_n  = 1'b0;
                            byte_idx_n = '0;
                        end else begin
                            state_n    = IDLE;
                            done_n     = 1'b1;
                            byte_idx_n = '0;
                        end
                    end
                    TOKEN: begin
                        state_n    = DATA;
                        shift_n    = next_byte;
                        byte_cnt_n = '0;
                    end
                    DATA: begin
                        if (byte_cnt == last_idx) begin
                            state_n    = CRC;
                            shift_n    = crc_step[15:8];
                            byte_idx_n = '0;
                        end else begin
                            byte_cnt_n = byte_cnt + 1'b1;
                            shift_n    = next_byte;
                        end
                    end
                    CRC: begin
                        if (byte_idx == 3'd0) begin
                            byte_idx_n = 3'd1;
                            shift_n    = crc[7:0];
                        end else begin
                            state_n    = IDLE;
                            done_n     = 1'b1;
                            byte_idx_n = '0;
                            byte_cnt_n = '0;
                        end
                    end
                    default: state_n = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            sck_prev  <= 1'b0;
            shift     <= '1;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            byte_cnt  <= '0;
            last_idx  <= '0;
            resp_data <= '0;
            resp_long <= 1'b0;
            pending   <= 1'b0;
            crc       <= '0;
            next_byte <= '0;
            req       <= 1'b0;
            req_d     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            sck_prev  <= io.io_SpiClk;
            shift     <= shift_n;
            bit_cnt   <= bit_cnt_n;
            byte_idx  <= byte_idx_n;
            byte_cnt  <= byte_cnt_n;
            last_idx  <= last_idx_n;
            resp_data <= resp_data_n;
            resp_long <= resp_long_n;
            pending   <= pending_n;
            crc       <= crc_n;
            next_byte <= next_byte_n;
            req       <= req_n;
            req_d     <= req;
            done      <= done_n;
        end
    end

    assign io.io_DO      = (state == IDLE || io.io_CS) ? 1'b1 : shift[7];
    assign io.io_Busy    = (state != IDLE);
    assign io.io_Done    = done;
    assign io.io_DataReq = req;

endmodule

// File: tb/tb_spi_slave_transmitter.sv
// Randomized bench for spi_slave_transmitter: the host side is modelled as an SPI master that
// records MISO bytes, compared against a byte-level model of the response/token/payload/CRC stream.
module tb_spi_slave_transmitter;
    localparam int SIZE_W = 12;
    localparam int HALF   = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    spi_slave_transmitter_if #(.SIZE_W(SIZE_W)) io ();

    spi_slave_transmitter #(.SIZE_W(SIZE_W)) dut (
        .clock (clock),
        .reset (reset),
        .io    (io)
    );

    int n_checks   = 0;
    int n_pass     = 0;
    int done_total = 0;
    int req_total  = 0;
    int req_base   = 0;

    logic [7:0] pay [0:1023];
    logic       rx_bits [$];
    logic [7:0] rx_bytes [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Host-side payload source: answers each request with the next byte of pay[].
    always @(negedge clock) begin
        int idx;
        if (io.io_Done) done_total++;
        if (io.io_DataReq) begin
            idx = req_total - req_base;
            io.io_DataByte = pay[idx % 1024];
            req_total++;
        end
    end

    function automatic logic [15:0] crc16(input int n);
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 0; i < n; i++) begin
            c = c ^ {pay[i], 8'h00};
            for (int k = 0; k < 8; k++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic one_bit();
        repeat (HALF) @(negedge clock);
        io.io_SpiClk = 1'b1;
        rx_bits.push_back(io.io_DO);
        repeat (HALF) @(negedge clock);
    endtask

    task automatic shift_bits(input int n);
        for (int i = 0; i < n; i++) begin
            one_bit();
            io.io_SpiClk = 1'b0;
        end
    endtask

    task automatic start_req(input bit rv, input bit rl, input logic [39:0] rd,
                             input bit ds, input int size);
        req_base = req_total;
        rx_bits.delete();
        io.io_CS = 1'b0;
        @(negedge clock);
        io.io_RespValid     = rv;
        io.io_RespLong      = rl;
        io.io_RespData      = rd;
        io.io_DataStart     = ds;
        io.io_DataBlockSize = SIZE_W'(size);
        @(negedge clock);
        io.io_RespValid     = 1'b0;
        io.io_DataStart     = 1'b0;
        io.io_RespLong      = 1'b0;
        io.io_RespData      = '0;
        io.io_DataBlockSize = '0;
    endtask

    task automatic collect_bytes();
        logic [7:0] b;
        rx_bytes.delete();
        for (int i = 0; i < rx_bits.size() / 8; i++) begin
            b = '0;
            for (int k = 0; k < 8; k++) b = {b[6:0], rx_bits[i*8+k]};
            rx_bytes.push_back(b);
        end
    endtask

    task automatic run_txn(input string name, input bit rv, input bit rl, input logic [39:0] rd,
                           input bit ds, input int size);
        logic [7:0]  exp [$];
        logic [15:0] c;
        int          eff, d0, r0;
        eff = (size == 0) ? 1 : size;
        if (rv) begin
            exp.push_back(rd[39:32]);
            if (rl) begin
                exp.push_back(rd[31:24]);
                exp.push_back(rd[23:16]);
                exp.push_back(rd[15:8]);
                exp.push_back(rd[7:0]);
            end
        end
        if (ds) begin
            exp.push_back(8'hFE);
            for (int i = 0; i < eff; i++) exp.push_back(pay[i]);
            c = crc16(eff);
            exp.push_back(c[15:8]);
            exp.push_back(c[7:0]);
        end
        d0 = done_total;
        r0 = req_total;
        start_req(rv, rl, rd, ds, size);
        check({name, "_busy_start"}, io.io_Busy, 1'b1);
        shift_bits(exp.size() * 8 - 1);
        one_bit();
        check({name, "_done_early"}, done_total - d0, 0);
        io.io_SpiClk = 1'b0;
        repeat (3) @(negedge clock);
        check({name, "_done_once"}, done_total - d0, 1);
        check({name, "_busy_end"}, io.io_Busy, 1'b0);
        check({name, "_do_idle"}, io.io_DO, 1'b1);
        check({name, "_req_count"}, req_total - r0, ds ? eff : 0);
        collect_bytes();
        check({name, "_nbytes"}, rx_bytes.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_bytes.size(); i++)
            check($sformatf("%s_byte%0d", name, i), rx_bytes[i], exp[i]);
        io.io_CS = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, sel, sz;
        logic [39:0] rd;
        io.io_SpiClk = 1'b0;
        io.io_CS = 1'b1;
        io.io_RespValid = 1'b0;
        io.io_RespData = '0;
        io.io_RespLong = 1'b0;
        io.io_DataStart = 1'b0;
        io.io_DataBlockSize = '0;
        io.io_DataByte = '0;

        repeat (5) @(negedge clock);
        check("rst_do", io.io_DO, 1'b1);
        check("rst_busy", io.io_Busy, 1'b0);
        check("rst_done", io.io_Done, 1'b0);
        check("rst_req", io.io_DataReq, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        run_txn("r1", 1'b1, 1'b0, 40'h01_2345_6789, 1'b0, 0);
        run_txn("r7", 1'b1, 1'b1, 40'h01_0000_01AA, 1'b0, 0);

        for (int i = 0; i < 512; i++) pay[i] = 8'hFF;
        run_txn("blk512", 1'b1, 1'b0, 40'h00_0000_0000, 1'b1, 512);
        if (rx_bytes.size() == 516)
            check("blk512_crc", {rx_bytes[514], rx_bytes[515]}, 16'h7FA1);
        else
            check("blk512_len", rx_bytes.size(), 516);

        pay[0] = 8'h5A;
        run_txn("short", 1'b0, 1'b0, '0, 1'b1, 1);
        pay[0] = 8'hC3;
        run_txn("size0", 1'b0, 1'b0, '0, 1'b1, 0);

        // Abort after token + 3 payload bytes.
        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
        d0 = done_total;
        r0 = req_total;
        start_req(1'b0, 1'b0, '0, 1'b1, 10);
        shift_bits(32);
        repeat (2) @(negedge clock);
        io.io_CS = 1'b1;
        #1;
        check("abort_do", io.io_DO, 1'b1);
        @(negedge clock);
        check("abort_busy", io.io_Busy, 1'b0);
        check("abort_req", req_total - r0, 4);
        collect_bytes();
        check("abort_tok", rx_bytes[0], 8'hFE);
        for (int i = 0; i < 3; i++) check($sformatf("abort_pay%0d", i), rx_bytes[i+1], pay[i]);
        repeat (4 * HALF) @(negedge clock);
        check("abort_nodone", done_total - d0, 0);
        run_txn("post_abort", 1'b1, 1'b0, 40'h01_0000_0000, 1'b0, 0);

        // Reset in the middle of an R7, with requests held during reset.
        d0 = done_total;
        start_req(1'b1, 1'b1, 40'h01_0000_01AA, 1'b0, 0);
        shift_bits(20);
        @(negedge clock);
        reset = 1'b1;
        io.io_RespValid = 1'b1;
        io.io_DataStart = 1'b1;
        io.io_DataBlockSize = SIZE_W'(4);
        repeat (3) @(negedge clock);
        check("mrst_busy", io.io_Busy, 1'b0);
        check("mrst_do", io.io_DO, 1'b1);
        check("mrst_done", io.io_Done, 1'b0);
        check("mrst_req", io.io_DataReq, 1'b0);
        io.io_RespValid = 1'b0;
        io.io_DataStart = 1'b0;
        io.io_DataBlockSize = '0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("mrst_ignored", io.io_Busy, 1'b0);
        check("mrst_nodone", done_total - d0, 0);
        io.io_CS = 1'b1;
        repeat (2) @(negedge clock);
        run_txn("post_rst", 1'b1, 1'b0, 40'h05_0000_0000, 1'b0, 0);

        for (int t = 0; t < 12; t++) begin
            sel = $urandom_range(0, 2);
            sz  = $urandom_range(0, 16);
            rd  = {8'($urandom), $urandom};
            for (int i = 0; i < 16; i++) pay[i] = 8'($urandom);
            run_txn($sformatf("rnd%0d", t), sel != 1, 1'($urandom), rd, sel != 0, sz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_transmitter.md
SPI_SLAVE_TRANSMITTER -- requirements
Module: SpiSlaveTransmitter

Interface
REQ-001 SHALL have parameter SIZE_W, default 12, width of the data block size input in bytes.
REQ-002 SHALL have port clock, input, 1, system clock; every register updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clock.
REQ-004 SHALL have port io_SpiClk, input, 1, raw SPI SCK from the host, sampled in the clock domain.
REQ-005 SHALL have port io_CS, input, 1, active-low chip select.
REQ-006 SHALL have port io_DO, output, 1, MISO serial data, MSB first.
REQ-007 SHALL have port io_RespValid, input, 1, request to send a response.
REQ-008 SHALL have port io_RespData, input, 40, response bytes, MSB-aligned: byte0 = [39:32].
REQ-009 SHALL have port io_RespLong, input, 1, 0 = 1-byte R1, 1 = 5-byte R3/R7.
REQ-010 SHALL have port io_DataStart, input, 1, request to send one data block after any pending response.
REQ-011 SHALL have port io_DataBlockSize, input, SIZE_W, block length in bytes, 1..2^SIZE_W-1.
REQ-012 SHALL have port io_DataReq, output, 1, one-cycle pulse requesting the next payload byte.
REQ-013 SHALL have port io_DataByte, input, 8, payload byte, valid on the cycle after io_DataReq.
REQ-014 SHALL have port io_Busy, output, 1, high while any transfer is pending or active.
REQ-015 SHALL have port io_Done, output, 1, one-cycle pulse when the last bit of a transfer has been shifted out.

Function
REQ-016 SHALL detect SCK edges by comparing io_SpiClk with its value registered on the previous clock; a falling edge is prev=1 and cur=0.
REQ-017 SHALL implement states IDLE, RESP, TOKEN, DATA, CRC, and SHALL leave IDLE only when io_CS=0.
REQ-018 SHALL accept io_RespValid and/or io_DataStart only in IDLE; requests in other states SHALL be ignored.
REQ-019 SHALL latch io_RespData, io_RespLong and io_DataBlockSize on acceptance.
REQ-020 When a response and a data start are accepted in the same cycle, SHALL send the response first, then the data block, with no gap bytes.
REQ-021 SHALL present the MSB of the first byte on io_DO on the clock after acceptance, and SHALL advance one bit per detected SCK falling edge.
REQ-022 SHALL load the next byte and present its MSB on the same clock as the 8th falling edge of the current byte.
REQ-023 RESP SHALL send 1 byte, or 5 bytes if RespLong=1; it then goes to TOKEN if data is pending, otherwise to IDLE.
REQ-024 TOKEN SHALL send 0xFE, then go to DATA.
REQ-025 DATA SHALL send exactly io_DataBlockSize bytes.
REQ-026 SHALL pulse io_DataReq once per payload byte, on the falling edge that starts bit 1 of the preceding byte (or of the token byte for payload byte 0).
REQ-027 SHALL register io_DataByte on the clock after each io_DataReq pulse.
REQ-028 CRC SHALL send a 16-bit CRC-CCITT (poly 0x1021, init 0x0000, no reflection, no final XOR) over the payload bytes, MSB first, then return to IDLE.
REQ-029 SHALL update the CRC bit-serially as each payload bit is shifted, and SHALL clear it on entering TOKEN.
REQ-030 SHALL drive io_DO=1 in IDLE and whenever io_CS=1.
REQ-031 SHALL pulse io_Done on the clock of the falling edge that ends the final bit (last R1/R7 byte when no data is pending, or CRC bit 0).
REQ-032 io_CS=1 in any non-IDLE state SHALL abort: go to IDLE, clear pending data, no io_Done pulse, and io_Busy=0 on the next clock.
REQ-033 SHALL treat io_DataBlockSize=0 as 1 byte.
REQ-034 Timing constraint: each SCK half-period SHALL be at least 4 clock periods; faster SCK is unsupported.

Reset
REQ-035 While reset=1, SHALL hold state=IDLE, io_DO=1, io_Busy=0, io_Done=0, io_DataReq=0, CRC=0, all counters 0, and no pending data.
REQ-036 Reset mid-transfer SHALL abort the transfer exactly as in REQ-035, regardless of io_CS.

Verification
REQ-037 R1: io_CS=0, io_RespValid with RespData[39:32]=0x01, RespLong=0, then 8 SCK -> io_DO bits 0,0,0,0,0,0,0,1; io_Done once; io_DO=1 afterwards.
REQ-038 R7: RespData=0x01000001AA, RespLong=1, 40 SCK -> bytes 0x01,0x00,0x00,0x01,0xAA; io_Busy low after io_Done.
REQ-039 Block: RespValid (0x00) and DataStart in the same cycle, size 512, all bytes 0xFF -> 0x00, 0xFE, 512×0xFF, CRC 0x7FA1; exactly 512 io_DataReq pulses.
REQ-040 Short block: size 1, byte 0x5A -> 0xFE, 0x5A, then CRC-CCITT(0x5A) MSB first; io_Done pulses on CRC bit 0.
REQ-041 Abort: io_CS raised after 3 payload bytes -> io_DO=1 and io_Busy=0 next clock, no io_Done; a following R1 request sends correctly.
REQ-042 Reset after 20 bits of an R7 -> all outputs at reset values; requests issued during reset are ignored.
